div_arbiter: RTL and testbench
==============================

# div_arbiter

Two-requester arbiter and sequencer for the shared 16-bit restoring divider. It sits between the operand sources (keypad-entry FSM and a second client) and the single divider datapath. It grants requests round-robin, issues a start pulse with stable operands, and waits for the divider's done pulse. It returns quotient and remainder on a shared response bus with valid/ready backpressure. Divide-by-zero is handled locally, and a watchdog recovers from a hung divider.

## Interface

Parameters:
- WIDTH, 16: operand and result width.
- TIMEOUT, 64: maximum cycles in WAIT before forced error response; 0 disables the watchdog.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- req0 / req1, in, 1: level request from client 0 / 1.
- dvd0 / dvd1, in, WIDTH: dividend for client 0 / 1; must be valid while reqN is high.
- dvs0 / dvs1, in, WIDTH: divisor for client 0 / 1; must be valid while reqN is high.
- ack0 / ack1, out, 1: one-cycle pulse; operands captured, client may drop or change req.
- div_start, out, 1: one-cycle start pulse to the divider.
- div_dividend / div_divisor, out, WIDTH: operands to the divider; held stable from div_start until leaving WAIT.
- div_done, in, 1: one-cycle completion pulse from the divider.
- div_quotient / div_remainder, in, WIDTH: divider results; valid when div_done is high.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer accepts the response.
- rsp_id, out, 1: client index owning the response.
- rsp_quotient / rsp_remainder, out, WIDTH: result.
- rsp_err, out, 1: result is from divide-by-zero or timeout.

## Operation

- The FSM has three states: IDLE, WAIT and RESP. All outputs are registered.
- **IDLE**
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that client.
  - If both are high, grant the client not granted last. The `last` pointer resets to 1, so req0 wins the first tie.
  - On grant:
    - Pulse ackN.
    - Latch the operands.
    - Set rsp_id to N.
    - Update `last` to N.
- **Grant with divisor != 0**
  - Drive div_dividend and div_divisor, pulse div_start.
  - Clear the watchdog counter and go to WAIT.
- **Grant with divisor == 0**
  - Do not pulse div_start.
  - Load rsp_quotient to all ones and rsp_remainder to the dividend, set rsp_err to 1.
  - Go to RESP.
- **WAIT**
  - div_done is ignored in the first WAIT cycle, the cycle div_start is high.
  - On any later div_done:
    - Load rsp_quotient from div_quotient and rsp_remainder from div_remainder.
    - Set rsp_err to 0.
    - Go to RESP.
  - Otherwise increment the watchdog counter.
  - If TIMEOUT != 0 and TIMEOUT WAIT cycles pass without an accepted div_done:
    - Set rsp_quotient and rsp_remainder to 0, rsp_err to 1.
    - Go to RESP.
- **RESP**
  - rsp_valid is high.
  - All rsp_* outputs are held stable until rsp_ready is sampled high; then clear rsp_valid and go to IDLE.
  - No grants or acks are issued in WAIT or RESP. Pending requests wait.
- **Spurious div_done**
  - In IDLE or RESP, div_done is ignored.
  - A divider result arriving after a timeout is discarded.
- **Reset**, at any time including mid-WAIT:
  - State goes to IDLE and `last` to 1.
  - ack0, ack1, div_start, rsp_valid, rsp_err and rsp_id go to 0.
  - rsp_quotient, rsp_remainder, div_dividend and div_divisor go to 0.
  - Any in-flight result is discarded.
- **Arithmetic:** the block does no division itself. The only results it produces are the all-ones quotient on divide-by-zero and zeros on timeout.

## Timing

- **Grant:** reqN is sampled at edge E. ackN, and div_start when applicable, are high in the cycle after E, for exactly one cycle.
- **Normal latency:** div_done is sampled high at edge D, which must be at least edge E+2. rsp_valid rises in the cycle after D.
- **Divide-by-zero:** rsp_valid rises in the cycle after E, coincident with ackN.
- **Timeout:** rsp_valid rises TIMEOUT cycles after the div_start cycle.
- **Response handshake:** rsp_ready sampled high at edge R means rsp_valid is low after R. The earliest next grant is sampled at edge R+1.
- **Re-request:** a client holding req high after ack is treated as a new request. That request competes at the next IDLE.
- **Single requester:** back-to-back throughput is one operation per divider latency + 3 cycles, with rsp_ready tied high.

## Test plan

1. **Basic divide:** req0 with dvd0=100, dvs0=7, and a divider model answering 18 cycles after start with q=14, r=2, rsp_ready=1. Required: ack0 and div_start for one cycle each with operands 100/7, then rsp_valid with id=0, q=14, r=2, err=0.
2. **Round-robin:** req0 and req1 held high together from reset. Required: grants alternate 0,1,0,1, and the first ack is ack0. After a solo req1, a tie goes to client 0.
3. **Divide-by-zero:** req1 with dvd1=0x1234, dvs1=0. Required: no div_start; ack1 and rsp_valid in the same cycle with q=0xFFFF, r=0x1234, err=1, id=1.
4. **Backpressure:** rsp_ready low for 5 cycles while req1 is pending. Required: rsp_* stable and no ack1 during the stall; ack1 arrives 2 cycles after the rsp_ready edge.
5. **Watchdog:** TIMEOUT=32 and the divider never answers. Required: rsp_valid 32 cycles after div_start with q=0, r=0, err=1. A late div_done in RESP or IDLE has no effect.
6. **Reset mid-operation:** rst asserted in WAIT. Required: all outputs 0 immediately. After release, req0 with 9/3 completes normally with q=3, r=0.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Signal bundle between div_arbiter, its two operand clients, the shared divider
// and the response consumer. The arbiter takes the slave view.
interface div_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0, req1;
  logic [WIDTH-1:0] dvd0, dvd1, dvs0, dvs1;
  logic             ack0, ack1;
  logic             div_start;
  logic [WIDTH-1:0] div_dividend, div_divisor;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient, div_remainder;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_quotient, rsp_remainder;

  modport slave (
    input  req0, req1, dvd0, dvd1, dvs0, dvs1,
    input  div_done, div_quotient, div_remainder, rsp_ready,
    output ack0, ack1, div_start, div_dividend, div_divisor,
    output rsp_valid, rsp_id, rsp_err, rsp_quotient, rsp_remainder
  );

  modport master (
    output req0, req1, dvd0, dvd1, dvs0, dvs1,
    output div_done, div_quotient, div_remainder, rsp_ready,
    input  ack0, ack1, div_start, div_dividend, div_divisor,
    input  rsp_valid, rsp_id, rsp_err, rsp_quotient, rsp_remainder
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared restoring divider, with
// local divide-by-zero handling and a watchdog for a divider that never answers.
module div_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  div_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CW-1:0]    wd_q, wd_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d, start_q, start_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic             valid_q, valid_d, id_q, id_d, err_q, err_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;

  logic             gnt;
  logic [WIDTH-1:0] g_dvd, g_dvs;
  logic             wd_expired;

  // On a tie the client that was not served last wins.
  assign gnt   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign g_dvd = gnt ? bus.dvd1 : bus.dvd0;
  assign g_dvs = gnt ? bus.dvs1 : bus.dvs0;

  assign wd_expired = (TIMEOUT != 0) && (wd_q == CW'(WD_LAST));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = wd_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    start_d = 1'b0;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    valid_d = valid_q;
    id_d    = id_q;
    err_d   = err_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          ack0_d = ~gnt;
          ack1_d = gnt;
          id_d   = gnt;
          last_d = gnt;
          if (g_dvs != '0) begin
            dvd_d   = g_dvd;
            dvs_d   = g_dvs;
            start_d = 1'b1;
            wd_d    = '0;
            state_d = S_WAIT;
          end else begin
            quo_d   = '1;
            rem_d   = g_dvd;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // start_q marks the first WAIT cycle, where a done pulse cannot be ours.
        if (!start_q && bus.div_done) begin
          quo_d   = bus.div_quotient;
          rem_d   = bus.div_remainder;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_RESP;
        end else if (wd_expired) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      start_q <= start_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      err_q   <= err_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.ack0          = ack0_q;
  assign bus.ack1          = ack1_q;
  assign bus.div_start     = start_q;
  assign bus.div_dividend  = dvd_q;
  assign bus.div_divisor   = dvs_q;
  assign bus.rsp_valid     = valid_q;
  assign bus.rsp_id        = id_q;
  assign bus.rsp_err       = err_q;
  assign bus.rsp_quotient  = quo_q;
  assign bus.rsp_remainder = rem_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: scenario tasks plus randomized traffic against a
// transaction-level model (grant order, arithmetic result, cycle latency).
module tb_div_arbiter;
  localparam int W  = 16;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_arbiter_if #(.WIDTH(W)) bus ();

  div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int div_lat  = 1;     // divider model: cycles from start cycle to done cycle
  bit m_last   = 1'b1;  // model: client served most recently

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W+2:0] rsp_now();
    return {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_quotient, bus.rsp_remainder};
  endfunction

  function automatic logic [4*W+5:0] outs_now();
    return {bus.ack0, bus.ack1, bus.div_start, bus.rsp_valid, bus.rsp_err, bus.rsp_id,
            bus.rsp_quotient, bus.rsp_remainder, bus.div_dividend, bus.div_divisor};
  endfunction

  // Expected response bus contents for a finished operation.
  function automatic logic [2*W+2:0] exp_rsp(input bit id, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input bit timeout);
    if (timeout) return {1'b1, id, 1'b1, {W{1'b0}}, {W{1'b0}}};
    if (b == 0)  return {1'b1, id, 1'b1, {W{1'b1}}, a};
    return {1'b1, id, 1'b0, a / b, a % b};
  endfunction

  function automatic bit exp_grant(input bit r0, input bit r1);
    if (r0 && r1) return !m_last;
    return r1;
  endfunction

  task automatic wait_ack(input int max, output int n);
    n = 0;
    while (!(bus.ack0 || bus.ack1) && n < max) begin
      tick();
      n++;
    end
    if (!(bus.ack0 || bus.ack1)) n = -1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bus.rsp_valid && n < max) begin
      tick();
      n++;
    end
    if (!bus.rsp_valid) n = -1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    tick();
  endtask

  // Divider model: answers div_lat cycles after the start cycle unless reset intervenes.
  initial begin : divider_model
    logic [W-1:0] a, b;
    int lat;
    bit aborted;
    bus.div_done = 1'b0;
    bus.div_quotient = '0;
    bus.div_remainder = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.div_start === 1'b1) begin
        a = bus.div_dividend;
        b = bus.div_divisor;
        lat = div_lat;
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk);
          #1;
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          bus.div_done = 1'b1;
          bus.div_quotient = (b == 0) ? '1 : a / b;
          bus.div_remainder = (b == 0) ? a : a % b;
          @(posedge clk);
          #1;
          bus.div_done = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    logic [4*W+5:0] z = '0;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (outs_now() !== z) begin
      n_errors++; $display("FAIL reset_outputs: got %h, expected %h", outs_now(), z);
    end
    rst = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (outs_now() !== z) begin
        n_errors++; $display("FAIL idle_quiet: got %h, expected %h", outs_now(), z);
      end
    end
  endtask

  task automatic test_basic();
    int n;
    bus.rsp_ready = 1'b1;
    div_lat = 18;
    bus.dvd0 = 16'd100; bus.dvs0 = 16'd7; bus.req0 = 1'b1;
    tick();
    n_checks++;
    if ({bus.ack0, bus.ack1, bus.div_start} !== 3'b101) begin
      n_errors++; $display("FAIL basic_grant: got %b, expected 101", {bus.ack0, bus.ack1, bus.div_start});
    end
    n_checks++;
    if ({bus.div_dividend, bus.div_divisor} !== {16'd100, 16'd7}) begin
      n_errors++; $display("FAIL basic_operands: got %h/%h, expected 0064/0007", bus.div_dividend, bus.div_divisor);
    end
    bus.req0 = 1'b0;
    m_last = 1'b0;
    tick();
    n_checks++;
    if ({bus.ack0, bus.div_start, bus.rsp_valid, bus.div_dividend, bus.div_divisor} !== {3'b000, 16'd100, 16'd7}) begin
      n_errors++; $display("FAIL basic_pulse_hold: got %b %h/%h, expected 000 0064/0007",
                           {bus.ack0, bus.div_start, bus.rsp_valid}, bus.div_dividend, bus.div_divisor);
    end
    wait_valid(40, n);
    n_checks++;
    if (n !== 18) begin
      n_errors++; $display("FAIL basic_latency: got %0d, expected 18", n);
    end
    n_checks++;
    if (rsp_now() !== {1'b1, 1'b0, 1'b0, 16'd14, 16'd2}) begin
      n_errors++; $display("FAIL basic_result: got %h, expected v1 id0 err0 q=000e r=0002", rsp_now());
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_accept: got rsp_valid %b, expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    bit p0 [7] = '{1, 1, 1, 1, 1, 0, 1};
    bit p1 [7] = '{1, 1, 1, 1, 1, 1, 1};
    logic [W-1:0] a0, b0, a1, b1, ea, eb;
    bit e;
    int n, lat;
    apply_reset();
    bus.rsp_ready = 1'b1;
    a0 = W'($urandom); b0 = W'($urandom_range(65535, 1));
    a1 = W'($urandom); b1 = W'($urandom_range(255, 1));
    bus.dvd0 = a0; bus.dvs0 = b0; bus.dvd1 = a1; bus.dvs1 = b1;
    for (int i = 0; i < 7; i++) begin
      bus.req0 = p0[i]; bus.req1 = p1[i];
      lat = $urandom_range(12, 1);
      div_lat = lat;
      e = exp_grant(p0[i], p1[i]);
      wait_ack(4, n);
      n_checks++;
      if (n !== ((i == 0) ? 1 : 2)) begin
        n_errors++; $display("FAIL rr_ack_gap[%0d]: got %0d cycles, expected %0d", i, n, (i == 0) ? 1 : 2);
      end
      n_checks++;
      if ({bus.ack0, bus.ack1} !== (e ? 2'b01 : 2'b10)) begin
        n_errors++; $display("FAIL rr_grant[%0d]: got ack0/ack1 %b, expected client %0d", i, {bus.ack0, bus.ack1}, e);
      end
      m_last = e;
      ea = e ? a1 : a0;
      eb = e ? b1 : b0;
      if (e) begin
        a1 = W'($urandom); b1 = W'($urandom_range(255, 1)); bus.dvd1 = a1; bus.dvs1 = b1;
      end else begin
        a0 = W'($urandom); b0 = W'($urandom_range(65535, 1)); bus.dvd0 = a0; bus.dvs0 = b0;
      end
      wait_valid(40, n);
      n_checks++;
      if (n !== lat + 1) begin
        n_errors++; $display("FAIL rr_latency[%0d]: got %0d, expected %0d", i, n, lat + 1);
      end
      n_checks++;
      if (rsp_now() !== exp_rsp(e, ea, eb, 1'b0)) begin
        n_errors++; $display("FAIL rr_result[%0d]: got %h, expected %h", i, rsp_now(), exp_rsp(e, ea, eb, 1'b0));
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_div_zero();
    logic [W-1:0] a;
    bit e;
    for (int i = 0; i < 2; i++) begin
      e = (i == 0);
      a = (i == 0) ? 16'h1234 : W'($urandom);
      if (e) begin
        bus.dvd1 = a; bus.dvs1 = '0; bus.req1 = 1'b1;
      end else begin
        bus.dvd0 = a; bus.dvs0 = '0; bus.req0 = 1'b1;
      end
      tick();
      n_checks++;
      if ({bus.ack0, bus.ack1, bus.div_start, bus.rsp_valid} !== {~e, e, 1'b0, 1'b1}) begin
        n_errors++; $display("FAIL dz_ack[%0d]: got ack0,ack1,start,valid %b, expected %b", i,
                             {bus.ack0, bus.ack1, bus.div_start, bus.rsp_valid}, {~e, e, 1'b0, 1'b1});
      end
      n_checks++;
      if (rsp_now() !== exp_rsp(e, a, '0, 1'b0)) begin
        n_errors++; $display("FAIL dz_result[%0d]: got %h, expected %h", i, rsp_now(), exp_rsp(e, a, '0, 1'b0));
      end
      m_last = e;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
        n_errors++; $display("FAIL dz_accept[%0d]: got rsp_valid %b, expected 0", i, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, a1, b1;
    int n, lat, lat1;
    a = W'($urandom); b = W'($urandom_range(65535, 1)); lat = $urandom_range(10, 1);
    bus.rsp_ready = 1'b0;
    div_lat = lat;
    bus.dvd0 = a; bus.dvs0 = b; bus.req0 = 1'b1;
    wait_ack(4, n);
    bus.req0 = 1'b0;
    m_last = 1'b0;
    n_checks++;
    if ({n == 1, bus.ack0} !== 2'b11) begin
      n_errors++; $display("FAIL bp_first_ack: got %0d cycles ack0=%b, expected 1 cycle ack0=1", n, bus.ack0);
    end
    wait_valid(40, n);
    n_checks++;
    if (n !== lat + 1) begin
      n_errors++; $display("FAIL bp_latency: got %0d, expected %0d", n, lat + 1);
    end
    a1 = W'($urandom); b1 = W'($urandom_range(65535, 1)); lat1 = $urandom_range(10, 1);
    bus.dvd1 = a1; bus.dvs1 = b1; bus.req1 = 1'b1;
    div_lat = lat1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (rsp_now() !== exp_rsp(1'b0, a, b, 1'b0)) begin
        n_errors++; $display("FAIL bp_hold[%0d]: got %h, expected %h", k, rsp_now(), exp_rsp(1'b0, a, b, 1'b0));
      end
      n_checks++;
      if (bus.ack1 !== 1'b0) begin
        n_errors++; $display("FAIL bp_no_ack[%0d]: got ack1 %b, expected 0", k, bus.ack1);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.ack1} !== 2'b00) begin
      n_errors++; $display("FAIL bp_release: got valid,ack1 %b, expected 00", {bus.rsp_valid, bus.ack1});
    end
    tick();
    n_checks++;
    if ({bus.ack1, bus.div_start} !== 2'b11) begin
      n_errors++; $display("FAIL bp_ack_after_ready: got ack1,start %b, expected 11", {bus.ack1, bus.div_start});
    end
    bus.req1 = 1'b0;
    m_last = 1'b1;
    wait_valid(40, n);
    n_checks++;
    if ({n == lat1 + 1, rsp_now()} !== {1'b1, exp_rsp(1'b1, a1, b1, 1'b0)}) begin
      n_errors++; $display("FAIL bp_second: got %0d cycles %h, expected %0d cycles %h", n, rsp_now(),
                           lat1 + 1, exp_rsp(1'b1, a1, b1, 1'b0));
    end
    tick();
  endtask

  task automatic test_watchdog();
    logic [W-1:0] a, b;
    int n;
    for (int i = 0; i < 2; i++) begin
      a = W'($urandom); b = W'($urandom_range(65535, 1));
      div_lat = TO + 8;
      bus.rsp_ready = (i == 1);
      bus.dvd1 = a; bus.dvs1 = b; bus.req1 = 1'b1;
      wait_ack(4, n);
      bus.req1 = 1'b0;
      m_last = 1'b1;
      n_checks++;
      if ({bus.ack1, bus.div_start} !== 2'b11) begin
        n_errors++; $display("FAIL wd_start[%0d]: got ack1,start %b, expected 11", i, {bus.ack1, bus.div_start});
      end
      wait_valid(TO + 10, n);
      n_checks++;
      if (n !== TO) begin
        n_errors++; $display("FAIL wd_latency[%0d]: got %0d, expected %0d", i, n, TO);
      end
      n_checks++;
      if (rsp_now() !== exp_rsp(1'b1, a, b, 1'b1)) begin
        n_errors++; $display("FAIL wd_result[%0d]: got %h, expected %h", i, rsp_now(), exp_rsp(1'b1, a, b, 1'b1));
      end
      if (i == 0) begin
        for (int k = 0; k < 12; k++) begin
          tick();
          n_checks++;
          if (rsp_now() !== exp_rsp(1'b1, a, b, 1'b1)) begin
            n_errors++; $display("FAIL wd_late_done_resp[%0d]: got %h, expected %h", k, rsp_now(), exp_rsp(1'b1, a, b, 1'b1));
          end
        end
        bus.rsp_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
          n_errors++; $display("FAIL wd_accept: got rsp_valid %b, expected 0", bus.rsp_valid);
        end
      end else begin
        for (int k = 0; k < 12; k++) begin
          tick();
          n_checks++;
          if ({bus.ack0, bus.ack1, bus.div_start, bus.rsp_valid} !== 4'b0000) begin
            n_errors++; $display("FAIL wd_late_done_idle[%0d]: got ack0,ack1,start,valid %b, expected 0000", k,
                                 {bus.ack0, bus.ack1, bus.div_start, bus.rsp_valid});
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4*W+5:0] z = '0;
    int n, lat;
    div_lat = 6;
    bus.dvd0 = W'($urandom); bus.dvs0 = W'($urandom_range(65535, 1)); bus.req0 = 1'b1;
    wait_ack(4, n);
    bus.req0 = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (outs_now() !== z) begin
      n_errors++; $display("FAIL rstmid_outputs: got %h, expected %h", outs_now(), z);
    end
    tick();
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (outs_now() !== z) begin
      n_errors++; $display("FAIL rstmid_quiet: got %h, expected %h", outs_now(), z);
    end
    lat = $urandom_range(10, 1);
    div_lat = lat;
    bus.dvd0 = 16'd9; bus.dvs0 = 16'd3; bus.req0 = 1'b1;
    wait_ack(4, n);
    bus.req0 = 1'b0;
    m_last = 1'b0;
    n_checks++;
    if ({n == 1, bus.ack0, bus.div_start} !== 3'b111) begin
      n_errors++; $display("FAIL rstmid_ack: got %0d cycles ack0,start %b, expected 1 cycle 11", n, {bus.ack0, bus.div_start});
    end
    wait_valid(40, n);
    n_checks++;
    if ({n == lat + 1, rsp_now()} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0}) begin
      n_errors++; $display("FAIL rstmid_result: got %0d cycles %h, expected %0d cycles q=3 r=0", n, rsp_now(), lat + 1);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a0, b0, a1, b1, ea, eb;
    bit r0, r1, e;
    int n, lat, stall;
    for (int i = 0; i < 30; i++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      a0 = W'($urandom); a1 = W'($urandom);
      b0 = ($urandom_range(4, 0) == 0) ? '0 : W'($urandom_range(65535, 1));
      b1 = ($urandom_range(4, 0) == 0) ? '0 : W'($urandom_range(300, 1));
      lat = $urandom_range(15, 1);
      stall = $urandom_range(3, 0);
      bus.dvd0 = a0; bus.dvs0 = b0; bus.dvd1 = a1; bus.dvs1 = b1;
      bus.req0 = r0; bus.req1 = r1;
      div_lat = lat;
      bus.rsp_ready = (stall == 0);
      e = exp_grant(r0, r1);
      wait_ack(4, n);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      m_last = e;
      n_checks++;
      if ({n == 1, bus.ack0, bus.ack1} !== {1'b1, ~e, e}) begin
        n_errors++; $display("FAIL rand_grant[%0d]: got %0d cycles ack0,ack1 %b, expected 1 cycle client %0d",
                             i, n, {bus.ack0, bus.ack1}, e);
      end
      ea = e ? a1 : a0;
      eb = e ? b1 : b0;
      wait_valid(40, n);
      n_checks++;
      if (n !== ((eb == 0) ? 0 : lat + 1)) begin
        n_errors++; $display("FAIL rand_latency[%0d]: got %0d, expected %0d", i, n, (eb == 0) ? 0 : lat + 1);
      end
      n_checks++;
      if (rsp_now() !== exp_rsp(e, ea, eb, 1'b0)) begin
        n_errors++; $display("FAIL rand_result[%0d]: got %h, expected %h", i, rsp_now(), exp_rsp(e, ea, eb, 1'b0));
      end
      for (int k = 0; k < stall; k++) begin
        tick();
        n_checks++;
        if (rsp_now() !== exp_rsp(e, ea, eb, 1'b0)) begin
          n_errors++; $display("FAIL rand_hold[%0d]: got %h, expected %h", i, rsp_now(), exp_rsp(e, ea, eb, 1'b0));
        end
      end
      bus.rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
        n_errors++; $display("FAIL rand_accept[%0d]: got rsp_valid %b, expected 0", i, bus.rsp_valid);
      end
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.dvd0 = '0; bus.dvd1 = '0; bus.dvs0 = '0; bus.dvs1 = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_div_zero();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: run still active at %0t, expected completion earlier", $time);
    $fatal(1);
  end
endmodule
